// File: rtl/ctrl_decode_stage_if.sv
// ID-stage to EX-stage control interface for ctrl_decode_stage.
// Optional jump signals exist only when CTRL_DECODE_JUMP_EN is defined.
interface ctrl_decode_stage_if #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned REG_W   = 5
);
  logic               id_valid_i;
  logic [OP_W-1:0]    instr_op_i;
  logic [REG_W-1:0]   id_rs_i;
  logic [REG_W-1:0]   id_rt_i;
  logic               flush_i;
  logic               hold_i;
  logic               stall_o;
  logic               ex_valid_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic               ex_reg_dst_o;
  logic               ex_mem_read_o;
  logic               ex_mem_write_o;
  logic               ex_branch_o;
  logic               ex_branch_ne_o;
  logic               ex_reg_write_o;
  logic               ex_mem_to_reg_o;
  logic [REG_W-1:0]   ex_rt_o;
  logic               ex_illegal_o;
`ifdef CTRL_DECODE_JUMP_EN
  logic               ex_jump_o;
  logic               id_jump_o;
`endif

  // Pipeline/control side driving the ID stage.
  modport master (
    output id_valid_i, instr_op_i, id_rs_i, id_rt_i, flush_i, hold_i,
    input  stall_o, ex_valid_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_mem_read_o,
           ex_mem_write_o, ex_branch_o, ex_branch_ne_o, ex_reg_write_o, ex_mem_to_reg_o,
           ex_rt_o, ex_illegal_o
`ifdef CTRL_DECODE_JUMP_EN
    , input ex_jump_o, id_jump_o
`endif
  );

  // Decode stage itself.
  modport slave (
    input  id_valid_i, instr_op_i, id_rs_i, id_rt_i, flush_i, hold_i,
    output stall_o, ex_valid_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_mem_read_o,
           ex_mem_write_o, ex_branch_o, ex_branch_ne_o, ex_reg_write_o, ex_mem_to_reg_o,
           ex_rt_o, ex_illegal_o
`ifdef CTRL_DECODE_JUMP_EN
    , output ex_jump_o, id_jump_o
`endif
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Pipelined main decoder: decodes the ID opcode, registers the control bundle into
// the ID/EX register, detects load-use hazards and inserts bubbles.
// Optional macro CTRL_DECODE_JUMP_EN adds the j opcode plus ex_jump_o / id_jump_o.
module ctrl_decode_stage #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned REG_W   = 5
) (
  input logic             clk_i,
  input logic             rst_i,
  ctrl_decode_stage_if.slave bus
);

  localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OpSlti  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpBne   = OP_W'(6'b000101);
`ifdef CTRL_DECODE_JUMP_EN
  localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);
`endif

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               branch_ne;
    logic               reg_write;
    logic               mem_to_reg;
    logic               illegal;
`ifdef CTRL_DECODE_JUMP_EN
    logic               jump;
`endif
  } ctrl_t;

  ctrl_t            dec;
  logic             uses_rt;
  logic             hazard;

  logic             ex_valid_q;
  ctrl_t            ex_ctrl_q;
  logic [REG_W-1:0] ex_rt_q;

  // Opcode decode; an invalid ID slot yields an all-zero bundle.
  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    case (bus.instr_op_i)
      OpRtype: begin
        dec.alu_op    = ALUOP_W'(3'b010);
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OpAddi: begin
        dec.alu_op    = ALUOP_W'(3'b000);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpSlti: begin
        dec.alu_op    = ALUOP_W'(3'b011);
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpLw: begin
        dec.alu_op     = ALUOP_W'(3'b000);
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OpSw: begin
        dec.alu_op    = ALUOP_W'(3'b000);
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OpBeq: begin
        dec.alu_op = ALUOP_W'(3'b001);
        dec.branch = 1'b1;
        uses_rt    = 1'b1;
      end
      OpBne: begin
        dec.alu_op    = ALUOP_W'(3'b001);
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        uses_rt       = 1'b1;
      end
`ifdef CTRL_DECODE_JUMP_EN
      OpJ: begin
        dec.jump = 1'b1;
      end
`endif
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (!bus.id_valid_i) begin
      dec = '0;
    end
  end

  // Load-use hazard: a valid load in EX writes a non-zero register that ID reads.
  always_comb begin
    hazard = bus.id_valid_i && ex_valid_q && ex_ctrl_q.mem_read && (ex_rt_q != '0) &&
             ((ex_rt_q == bus.id_rs_i) || (uses_rt && (ex_rt_q == bus.id_rt_i)));
  end

  assign bus.stall_o = (hazard && !bus.flush_i) || bus.hold_i;

  // ID/EX register: reset, then flush, then hold, then hazard bubble, then load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rt_q    <= '0;
    end else if (bus.flush_i || (!bus.hold_i && hazard)) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rt_q    <= '0;
    end else if (!bus.hold_i) begin
      ex_valid_q <= bus.id_valid_i;
      ex_ctrl_q  <= dec;
      ex_rt_q    <= bus.id_rt_i;
    end
  end

  assign bus.ex_valid_o      = ex_valid_q;
  assign bus.ex_alu_op_o     = ex_ctrl_q.alu_op;
  assign bus.ex_alu_src_o    = ex_ctrl_q.alu_src;
  assign bus.ex_reg_dst_o    = ex_ctrl_q.reg_dst;
  assign bus.ex_mem_read_o   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write_o  = ex_ctrl_q.mem_write;
  assign bus.ex_branch_o     = ex_ctrl_q.branch;
  assign bus.ex_branch_ne_o  = ex_ctrl_q.branch_ne;
  assign bus.ex_reg_write_o  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_to_reg_o = ex_ctrl_q.mem_to_reg;
  assign bus.ex_rt_o         = ex_rt_q;
  assign bus.ex_illegal_o    = ex_ctrl_q.illegal;
`ifdef CTRL_DECODE_JUMP_EN
  assign bus.ex_jump_o       = ex_ctrl_q.jump;
  assign bus.id_jump_o       = bus.id_valid_i && (bus.instr_op_i == OpJ) && !bus.flush_i;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage against an instruction-level reference model.
// Honours CTRL_DECODE_JUMP_EN the same way the design does.
module tb_ctrl_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage_if bus ();

  ctrl_decode_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  localparam logic [5:0] R_OP = 6'b000000, ADDI = 6'b001000, SLTI = 6'b001010,
                         LW   = 6'b100011, SW   = 6'b101011, BEQ  = 6'b000100,
                         BNE  = 6'b000101, J_OP = 6'b000010, BAD  = 6'b111111;

  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic       alu_src, reg_dst, mem_read, mem_write, branch, branch_ne;
    logic       reg_write, mem_to_reg, illegal, jump;
    logic [4:0] rt;
  } ex_t;

  ex_t model = '0;

  // Instruction table: {alu_op, alu_src, reg_dst, mem_read, mem_write, branch, branch_ne,
  // reg_write, mem_to_reg}; unknown opcodes are illegal.
  function automatic ex_t ref_decode(input logic valid, input logic [5:0] op,
                                     input logic [4:0] rt);
    ex_t e = '0;
    logic [10:0] row = '0;
    logic known = 1'b1;
    case (op)
      R_OP:    row = 11'b010_01000010;
      ADDI:    row = 11'b000_10000010;
      SLTI:    row = 11'b011_10000010;
      LW:      row = 11'b000_10100011;
      SW:      row = 11'b000_10010000;
      BEQ:     row = 11'b001_00001000;
      BNE:     row = 11'b001_00001100;
`ifdef CTRL_DECODE_JUMP_EN
      J_OP:    e.jump = 1'b1;
`endif
      default: known = 1'b0;
    endcase
    {e.alu_op, e.alu_src, e.reg_dst, e.mem_read, e.mem_write, e.branch, e.branch_ne,
     e.reg_write, e.mem_to_reg} = row;
    e.illegal = !known;
    if (!valid) e = '0;
    e.valid = valid;
    e.rt    = rt;
    return e;
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == R_OP) || (op == SW) || (op == BEQ) || (op == BNE);
  endfunction

  // Does the ID instruction read a register the load now in EX is still fetching?
  function automatic logic ref_hazard();
    return bus.id_valid_i && model.valid && model.mem_read && (model.rt != 0) &&
           ((model.rt == bus.id_rs_i) || (reads_rt(bus.instr_op_i) && model.rt == bus.id_rt_i));
  endfunction

  function automatic logic exp_stall();
    return (ref_hazard() && !bus.flush_i) || bus.hold_i;
  endfunction

  // rt is meaningless in a bubble, so it is not compared there.
  function automatic ex_t masked(input ex_t v);
    ex_t m = v;
    if (!m.valid) m.rt = '0;
    return m;
  endfunction

  function automatic ex_t observed();
    ex_t o;
    o.valid      = bus.ex_valid_o;
    o.alu_op     = bus.ex_alu_op_o;
    o.alu_src    = bus.ex_alu_src_o;
    o.reg_dst    = bus.ex_reg_dst_o;
    o.mem_read   = bus.ex_mem_read_o;
    o.mem_write  = bus.ex_mem_write_o;
    o.branch     = bus.ex_branch_o;
    o.branch_ne  = bus.ex_branch_ne_o;
    o.reg_write  = bus.ex_reg_write_o;
    o.mem_to_reg = bus.ex_mem_to_reg_o;
    o.illegal    = bus.ex_illegal_o;
`ifdef CTRL_DECODE_JUMP_EN
    o.jump       = bus.ex_jump_o;
`else
    o.jump       = 1'b0;
`endif
    o.rt         = bus.ex_rt_o;
    return o;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl, input logic hd);
    @(negedge clk);
    rst = r;
    bus.id_valid_i = v;
    bus.instr_op_i = op;
    bus.id_rs_i = rs;
    bus.id_rt_i = rt;
    bus.flush_i = fl;
    bus.hold_i = hd;
    #1;
  endtask

  // Advance one edge and update the reference in the same priority order as the pipeline.
  task automatic step();
    @(posedge clk);
    if (rst) model = '0;
    else if (bus.flush_i) model = '0;
    else if (bus.hold_i) model = model;
    else if (ref_hazard()) model = '0;
    else model = ref_decode(bus.id_valid_i, bus.instr_op_i, bus.id_rt_i);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, LW, 5'd1, 5'd5, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (observed() !== ex_t'('0)) begin
      errors++; $display("FAIL reset_ex: got %h expected 0", observed());
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o);
    end
    drive(1'b0, 1'b1, LW, 5'd1, 5'd5, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.ex_mem_read_o, bus.ex_alu_op_o, bus.ex_mem_to_reg_o} !== 5'b1_000_1) begin
      errors++;
      $display("FAIL reset_first_lw: got %b%b%b expected 1_000_1", bus.ex_mem_read_o,
               bus.ex_alu_op_o, bus.ex_mem_to_reg_o);
    end
    checks++;
    if (masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL reset_first_bundle: got %h expected %h", observed(), model);
    end
  endtask

  task automatic test_stream();
    logic [5:0] ops [6] = '{R_OP, ADDI, SLTI, SW, BEQ, BNE};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, ops[i], 5'(10 + i), 5'(20 + i), 1'b0, 1'b0);
      checks++;
      if (bus.stall_o !== 1'b0) begin
        errors++; $display("FAIL stream_stall[%0d]: got %b expected 0", i, bus.stall_o);
      end
      step();
      checks++;
      if (masked(observed()) !== masked(model)) begin
        errors++; $display("FAIL stream_ex[%0d]: got %h expected %h", i, observed(), model);
      end
      checks++;
      if (bus.ex_branch_ne_o !== (ops[i] == BNE)) begin
        errors++;
        $display("FAIL stream_bne[%0d]: got %b expected %b", i, bus.ex_branch_ne_o, ops[i] == BNE);
      end
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b1, LW, 5'd1, 5'd8, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, R_OP, 5'd8, 5'd2, 1'b0, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL loaduse_stall: got %b expected 1", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b0 || masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL loaduse_bubble: got %h expected %h", observed(), model);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL loaduse_release: got %b expected 0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b1 || masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL loaduse_add: got %h expected %h", observed(), model);
    end
  endtask

  task automatic test_no_stall();
    drive(1'b0, 1'b1, LW, 5'd1, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, R_OP, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL rt0_stall: got %b expected 0", bus.stall_o);
    end
    step();
    drive(1'b0, 1'b1, LW, 5'd1, 5'd9, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, ADDI, 5'd3, 5'd9, 1'b0, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL addi_rt_stall: got %b expected 0", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b1 || masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL addi_loaded: got %h expected %h", observed(), model);
    end
  endtask

  task automatic test_flush_hold_illegal();
    drive(1'b0, 1'b1, LW, 5'd1, 5'd7, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, R_OP, 5'd7, 5'd7, 1'b1, 1'b1);
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL flush_hold_stall: got %b expected 1", bus.stall_o);
    end
    step();
    checks++;
    if (bus.ex_valid_o !== 1'b0 || masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL flush_bubble: got %h expected %h", observed(), model);
    end
    drive(1'b0, 1'b1, BAD, 5'd4, 5'd5, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.ex_illegal_o !== 1'b1 || masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL illegal_op: got %h expected %h", observed(), model);
    end
  endtask

  task automatic test_jump();
    drive(1'b0, 1'b1, J_OP, 5'd4, 5'd5, 1'b0, 1'b0);
`ifdef CTRL_DECODE_JUMP_EN
    checks++;
    if (bus.id_jump_o !== 1'b1) begin
      errors++; $display("FAIL id_jump: got %b expected 1", bus.id_jump_o);
    end
    step();
    checks++;
    if (bus.ex_jump_o !== 1'b1 || bus.ex_illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL ex_jump: got jump=%b illegal=%b expected 1/0", bus.ex_jump_o, bus.ex_illegal_o);
    end
`else
    step();
    checks++;
    if (bus.ex_illegal_o !== 1'b1) begin
      errors++; $display("FAIL j_illegal: got %b expected 1", bus.ex_illegal_o);
    end
`endif
    checks++;
    if (masked(observed()) !== masked(model)) begin
      errors++; $display("FAIL jump_bundle: got %h expected %h", observed(), model);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 1'b1, LW, 5'd1, 5'd4, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, R_OP, 5'd4, 5'd6, 1'b0, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL midstall_pre: got %b expected 1", bus.stall_o);
    end
    step();
    drive(1'b0, 1'b1, R_OP, 5'd4, 5'd6, 1'b0, 1'b1);
    checks++;
    if (bus.stall_o !== 1'b1 || observed() !== ex_t'('0)) begin
      errors++; $display("FAIL midstall_hold: got %b/%h expected 1/0", bus.stall_o, observed());
    end
    drive(1'b0, 1'b1, R_OP, 5'd4, 5'd6, 1'b0, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL midstall_post: got %b expected 0", bus.stall_o);
    end
    step();
  endtask

  task automatic test_random();
    logic [5:0] ops [10] = '{R_OP, ADDI, SLTI, LW, LW, SW, BEQ, BNE, J_OP, BAD};
    logic [5:0] op;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0), op,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      checks++;
      if (bus.stall_o !== exp_stall()) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, bus.stall_o, exp_stall());
      end
`ifdef CTRL_DECODE_JUMP_EN
      checks++;
      if (bus.id_jump_o !== (bus.id_valid_i && op == J_OP && !bus.flush_i)) begin
        errors++; $display("FAIL rand_id_jump[%0d]: got %b", i, bus.id_jump_o);
      end
`endif
      step();
      checks++;
      if (masked(observed()) !== masked(model)) begin
        errors++; $display("FAIL rand_ex[%0d]: got %h expected %h", i, observed(), model);
      end
    end
  endtask

  initial begin
    bus.id_valid_i = 1'b0;
    bus.instr_op_i = '0;
    bus.id_rs_i = '0;
    bus.id_rt_i = '0;
    bus.flush_i = 1'b0;
    bus.hold_i = 1'b0;
    test_reset();
    test_stream();
    test_load_use();
    test_no_stall();
    test_flush_hold_illegal();
    test_jump();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
